// File: rtl/dianthus_pkg.sv
// Shared definitions for the random nibble packer: default widths, FSM encoding
// and the packed word width.
package dianthus_pkg;

   localparam int unsigned NIB_W_DEF = 4;
   localparam int unsigned NIBS_DEF  = 4;
   localparam int unsigned CNT_W_DEF = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_e;

   function automatic int unsigned word_width(input int unsigned nib_w, input int unsigned nibs);
      return nib_w * nibs;
   endfunction

endpackage

// File: rtl/rand_nibble_packer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != CNT_MAX)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rand_nibble_packer.sv
// Packs consecutive generator nibbles (LSB-first) into words on a valid/ready
// output and counts generator period wraps for health monitoring.
module rand_nibble_packer
   import dianthus_pkg::*;
#(
   parameter int unsigned NIB_W = NIB_W_DEF,
   parameter int unsigned NIBS  = NIBS_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                stop,
   output logic                                gen_en,
   input  logic [NIB_W-1:0]                    rnd_in,
   input  logic                                wrap_in,
   output logic [word_width(NIB_W, NIBS)-1:0]  word_out,
   output logic                                word_valid,
   input  logic                                word_ready,
   output logic [CNT_W-1:0]                    wrap_cnt,
   output logic                                busy
);

   localparam int unsigned WORD_W = word_width(NIB_W, NIBS);
   localparam int unsigned IDX_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBS - 1);

   state_e             state;
   logic [IDX_W-1:0]   nib_idx;
   logic [WORD_W-1:0]  shift_q;
   logic               stop_pend;

   logic               last_c;
   logic               stall_c;
   logic               abort_c;
   logic               start_acc_c;
   logic [WORD_W-1:0]  word_nxt_c;

   // A full output register only blocks the edge that would complete the next word.
   assign last_c      = (nib_idx == IDX_LAST);
   assign stall_c     = last_c && word_valid && !word_ready;
   assign gen_en      = (state == ST_FILL) && !stall_c;
   assign busy        = (state == ST_FILL);
   assign start_acc_c = (state == ST_IDLE) && start && !stop;
   assign abort_c     = (stop || stop_pend) && (nib_idx == '0);

   // Current shift contents with this cycle's nibble dropped into its slot.
   always_comb begin
      word_nxt_c = shift_q;
      for (int i = 0; i < int'(NIBS); i++) begin
         if (nib_idx == IDX_W'(i)) begin
            word_nxt_c[i*NIB_W +: NIB_W] = rnd_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         nib_idx    <= '0;
         shift_q    <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         stop_pend  <= 1'b0;
      end else begin
         if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start_acc_c) begin
                  state     <= ST_FILL;
                  nib_idx   <= '0;
                  shift_q   <= '0;
                  stop_pend <= 1'b0;
               end
            end

            ST_FILL: begin
               if (stop) begin
                  stop_pend <= 1'b1;
               end
               // Nothing of the current word sampled yet: a stop ends packing right away.
               if (abort_c) begin
                  state     <= ST_IDLE;
                  stop_pend <= 1'b0;
               end else if (gen_en) begin
                  if (last_c) begin
                     word_out   <= word_nxt_c;
                     word_valid <= 1'b1;
                     shift_q    <= '0;
                     nib_idx    <= '0;
                     if (stop || stop_pend) begin
                        state     <= ST_IDLE;
                        stop_pend <= 1'b0;
                     end
                  end else begin
                     shift_q <= word_nxt_c;
                     nib_idx <= nib_idx + IDX_W'(1);
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_wrap_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wrap_in && busy),
      .clr   (start_acc_c),
      .q     (wrap_cnt)
   );

endmodule
